alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. an execute stage and a branch/address-compute unit.
- Each requester issues operands plus a 4-bit op over a valid/ready handshake.
- Grants use two-way round-robin; the result and zero flag are registered and returned to the owning requester over its own valid/ready response channel.
- Latency 1 cycle; throughput 1 op/cycle when the response side is ready.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- PRIO_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_a, req0_b  in  32  operands.
- req0_op  in  4  ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 held.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_r  out  32  result.
- rsp0_zero  out  1  result==0.
- rsp1_valid, rsp1_ready, rsp1_r, rsp1_zero  same as the rsp0 group, for requester 1.

Behaviour:
- State is one output register: full flag, owner bit, r[31:0], zero. Plus a priority bit prio.
- The output register is free when it is empty, or when it is full and the owner's rsp_ready=1 this cycle (pass-through).
- Grant, combinational, only when the output register is free:
  - only one req valid: that requester wins;
  - both valid: requester prio wins;
  - none valid: no grant.
- reqN_ready=1 only for the winner. The loser sees ready=0 and keeps its request.
- On accept (valid&ready):
  - ALU operands and op are muxed from the winner;
  - r, zero and owner are loaded at the clock edge; full=1;
  - prio becomes the non-winner.
- prio is unchanged on cycles with no accept.
- rspN_valid = full & (owner==N). Both rsp_valid are never high together.
- r and zero are held stable while valid is high and ready is low.
- Response handshake without a new accept: full=0 next cycle.
- Response handshake with a new accept in the same cycle: the new result is loaded with no bubble.
- Requester protocol: once reqN_valid=1, payload stays stable until ready. The bench asserts this; the DUT does not check it.
- Combinational path rspN_ready -> reqM_ready is permitted and documented.
- Op encoding, from the shared package:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB;
  - 0101 MUL low, 0110 MULH signed, 0111 MULHU;
  - 1000 SLL, 1001 SRL, 1010/1011 SRA;
  - 1100 SLT, 1101-1111 SLTU.
- Shift amount is B[4:0]. Arithmetic wraps modulo 2^32.
- Reset, including mid-operation:
  - full=0 and both rsp_valid=0 in the cycle after rst is sampled;
  - a pending result is discarded;
  - prio=PRIO_INIT; rsp_r=0, rsp_zero=0;
  - both req_ready=0 while rst=1.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 4-bit enum with the codes above;
  - localparam DATA_W_C=32;
  - typedef alu_rsp_t, a struct of r and zero.
- One sub-module: the team's existing alu, instantiated once on the muxed operands. Arbitration stays inline; it is too small to split.

Test Plan:
- req0 only, A=5, B=7, op=0011 -> next cycle rsp0_valid=1, r=12, zero=0; rsp1_valid stays 0.
- After reset with PRIO_INIT=0, both valid and held for 4 ops each, rsp ready=1:
  - req0 SUB 9-9 wins first -> rsp0 r=0, zero=1;
  - grant order is 0,1,0,1,...
- rsp0_ready=0 for 3 cycles with req1 waiting:
  - rsp0 holds r constant; req0_ready=req1_ready=0;
  - in the cycle rsp0_ready rises, req1 is accepted and rsp1_valid follows next cycle.
- Arithmetic spot checks via req1:
  - A=0x80000000, B=4, op=1010 -> 0xF8000000;
  - A=0xFFFFFFFF, B=2, op=0111 -> 0x00000001;
  - A=-1, B=1, op=1100 -> 1.
- Reset mid-operation: assert rst while rsp1_valid=1 -> next cycle both rsp_valid=0, prio=PRIO_INIT; the stale result never reappears.
- Streaming: req1 only, rsp1_ready=1, 8 back-to-back ADDs of i+i -> 8 responses in 8 consecutive cycles, in order, r=2i.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, data width and the registered result type.
package alu_pkg;

  localparam int unsigned DATA_W_C = 32;

  typedef enum logic [3:0] {
    OpAnd   = 4'h0,
    OpOr    = 4'h1,
    OpXor   = 4'h2,
    OpAdd   = 4'h3,
    OpSub   = 4'h4,
    OpMul   = 4'h5,
    OpMulh  = 4'h6,
    OpMulhu = 4'h7,
    OpSll   = 4'h8,
    OpSrl   = 4'h9,
    OpSra   = 4'ha,
    OpSra2  = 4'hb,
    OpSlt   = 4'hc,
    OpSltu  = 4'hd,
    OpSltu2 = 4'he,
    OpSltu3 = 4'hf
  } alu_op_t;

  typedef struct packed {
    logic [DATA_W_C-1:0] r;
    logic                zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared ALU arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_W_C-1:0] req0_a;
  logic [DATA_W_C-1:0] req0_b;
  logic [3:0]          req0_op;
  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_W_C-1:0] req1_a;
  logic [DATA_W_C-1:0] req1_b;
  logic [3:0]          req1_op;

  logic                rsp0_valid;
  logic                rsp0_ready;
  logic [DATA_W_C-1:0] rsp0_r;
  logic                rsp0_zero;
  logic                rsp1_valid;
  logic                rsp1_ready;
  logic [DATA_W_C-1:0] rsp1_r;
  logic                rsp1_zero;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_r, rsp0_zero,
    input  rsp1_valid, rsp1_r, rsp1_zero
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_r, rsp0_zero,
    output rsp1_valid, rsp1_r, rsp1_zero
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU: logic, add/sub, multiply, shifts and compares.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W_C-1:0] a_i,
  input  logic [DATA_W_C-1:0] b_i,
  input  alu_op_t             op_i,
  output alu_rsp_t            rsp_o
);

  logic [4:0]          shamt;
  logic [63:0]         prod_u;
  logic [DATA_W_C-1:0] mulh_s;
  logic [DATA_W_C-1:0] r;

  assign shamt  = b_i[4:0];
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};
  // Signed high word derived from the unsigned product, so one multiplier serves all three ops.
  assign mulh_s = prod_u[63:32] - (a_i[31] ? b_i : '0) - (b_i[31] ? a_i : '0);

  always_comb begin
    r = '0;
    case (op_i)
      OpAnd:           r = a_i & b_i;
      OpOr:            r = a_i | b_i;
      OpXor:           r = a_i ^ b_i;
      OpAdd:           r = a_i + b_i;
      OpSub:           r = a_i - b_i;
      OpMul:           r = prod_u[31:0];
      OpMulh:          r = mulh_s;
      OpMulhu:         r = prod_u[63:32];
      OpSll:           r = a_i << shamt;
      OpSrl:           r = a_i >> shamt;
      OpSra, OpSra2:   r = $unsigned($signed(a_i) >>> shamt);
      OpSlt:           r = {31'b0, $signed(a_i) < $signed(b_i)};
      default:         r = {31'b0, a_i < b_i};
    endcase
  end

  assign rsp_o.r    = r;
  assign rsp_o.zero = (r == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a single registered result slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  if (DATA_W != DATA_W_C) begin : g_bad_width
    $error("alu_arbiter supports DATA_W=32 only");
  end
  if (PRIO_INIT > 1) begin : g_bad_prio
    $error("alu_arbiter PRIO_INIT must be 0 or 1");
  end

  logic        full_q, full_d;
  logic        owner_q, owner_d;
  logic        prio_q, prio_d;
  alu_rsp_t    rsp_q, rsp_d;

  logic              out_ready;
  logic              free;
  logic              grant0, grant1;
  logic [DATA_W-1:0] alu_a, alu_b;
  alu_op_t           alu_op;
  alu_rsp_t          alu_rsp;

  // Slot frees when empty or when its owner drains it this cycle (rsp_ready -> req_ready path).
  assign out_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign free      = ~full_q | out_ready;

  assign grant0 = ~rst & free & bus.req0_valid & (~bus.req1_valid | ~prio_q);
  assign grant1 = ~rst & free & bus.req1_valid & (~bus.req0_valid | prio_q);

  assign alu_a  = grant1 ? bus.req1_a : bus.req0_a;
  assign alu_b  = grant1 ? bus.req1_b : bus.req0_b;
  assign alu_op = alu_op_t'(grant1 ? bus.req1_op : bus.req0_op);

  alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .rsp_o (alu_rsp)
  );

  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    rsp_d   = rsp_q;
    if (grant0 | grant1) begin
      full_d  = 1'b1;
      owner_d = grant1;
      prio_d  = grant0;
      rsp_d   = alu_rsp;
    end else if (full_q & out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'(PRIO_INIT);
      rsp_q   <= '0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = full_q & ~owner_q;
  assign bus.rsp1_valid = full_q & owner_q;
  assign bus.rsp0_r     = rsp_q.r;
  assign bus.rsp1_r     = rsp_q.r;
  assign bus.rsp0_zero  = rsp_q.zero;
  assign bus.rsp1_zero  = rsp_q.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst;
  alu_arbiter_if bus ();

  alu_arbiter #(
    .DATA_W    (32),
    .PRIO_INIT (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Model: one result slot, who owns it, and whose turn it is on a tie.
  logic        m_known = 1'b0;
  logic        m_full, m_owner, m_prio, m_zero;
  logic [31:0] m_r;
  logic        last_acc0, last_acc1;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int              sh, ia, ib;
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sh = int'(b[4:0]);
    ia = a; ib = b; sa = ia; sb = ib; ps = sa * sb;
    ua = a; ub = b; pu = ua * ub;
    case (op)
      4'd0:        return a & b;
      4'd1:        return a | b;
      4'd2:        return a ^ b;
      4'd3:        return a + b;
      4'd4:        return a - b;
      4'd5:        return pu[31:0];
      4'd6:        return ps[63:32];
      4'd7:        return pu[63:32];
      4'd8:        return a << sh;
      4'd9:        return a >> sh;
      4'd10, 4'd11: return ia >>> sh;
      4'd12:       return (ia < ib) ? 32'd1 : 32'd0;
      default:     return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // One clock: check DUT against model at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    logic free, e0, e1;
    @(negedge clk);
    free = !m_full || (m_owner ? bus.rsp1_ready : bus.rsp0_ready);
    e0 = !rst && free && bus.req0_valid && (!bus.req1_valid || !m_prio);
    e1 = !rst && free && bus.req1_valid && (!bus.req0_valid || m_prio);
    tests_run++;
    if (bus.req0_ready !== e0) begin
      fails++; $display("FAIL req0_ready t=%0t got %b exp %b", $time, bus.req0_ready, e0);
    end
    tests_run++;
    if (bus.req1_ready !== e1) begin
      fails++; $display("FAIL req1_ready t=%0t got %b exp %b", $time, bus.req1_ready, e1);
    end
    if (m_known) begin
      tests_run++;
      if (bus.rsp0_valid !== (m_full && !m_owner) || bus.rsp1_valid !== (m_full && m_owner)) begin
        fails++;
        $display("FAIL rsp_valid t=%0t got %b%b exp %b%b", $time, bus.rsp1_valid,
                 bus.rsp0_valid, m_full && m_owner, m_full && !m_owner);
      end
      if (m_full) begin
        tests_run++;
        if ((m_owner ? bus.rsp1_r : bus.rsp0_r) !== m_r ||
            (m_owner ? bus.rsp1_zero : bus.rsp0_zero) !== m_zero) begin
          fails++;
          $display("FAIL rsp_data t=%0t got %h/%b exp %h/%b", $time,
                   m_owner ? bus.rsp1_r : bus.rsp0_r, m_owner ? bus.rsp1_zero : bus.rsp0_zero,
                   m_r, m_zero);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1; m_full = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_r = '0; m_zero = 1'b0;
    end else if (e0 || e1) begin
      m_r     = e1 ? ref_alu(bus.req1_a, bus.req1_b, bus.req1_op)
                   : ref_alu(bus.req0_a, bus.req0_b, bus.req0_op);
      m_zero  = (m_r == 32'd0);
      m_full  = 1'b1;
      m_owner = e1;
      m_prio  = e0;
    end else if (m_full && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
      m_full = 1'b0;
    end
    last_acc0 = e0;
    last_acc1 = e1;
    #1;
  endtask

  // Requester protocol monitor: a stalled request must keep valid and payload.
  logic        pv0, pv1;
  logic [67:0] pp0, pp1;
  always @(negedge clk) begin
    if (!rst && pv0 && (!bus.req0_valid || {bus.req0_a, bus.req0_b, bus.req0_op} !== pp0)) begin
      fails++; $display("FAIL req0_hold t=%0t payload changed while stalled", $time);
    end
    if (!rst && pv1 && (!bus.req1_valid || {bus.req1_a, bus.req1_b, bus.req1_op} !== pp1)) begin
      fails++; $display("FAIL req1_hold t=%0t payload changed while stalled", $time);
    end
    pv0 <= bus.req0_valid && !bus.req0_ready && !rst;
    pv1 <= bus.req1_valid && !bus.req1_ready && !rst;
    pp0 <= {bus.req0_a, bus.req0_b, bus.req0_op};
    pp1 <= {bus.req1_a, bus.req1_b, bus.req1_op};
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got %b%b exp 00", bus.req1_ready, bus.req0_ready);
    end
    idle_inputs();
    rst = 1'b0;
    tests_run++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b%b exp 00", bus.rsp1_valid, bus.rsp0_valid);
    end
    tests_run++;
    if (bus.rsp0_r !== 32'd0 || bus.rsp0_zero !== 1'b0) begin
      fails++; $display("FAIL reset_data got %h/%b exp 0/0", bus.rsp0_r, bus.rsp0_zero);
    end
  endtask

  task automatic test_single_add();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_op = 4'b0011;
    tick();
    bus.req0_valid = 1'b0;
    tests_run++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_r !== 32'd12 || bus.rsp0_zero !== 1'b0 ||
        bus.rsp1_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_add got v0=%b r=%h z=%b v1=%b exp v0=1 r=0000000c z=0 v1=0",
               bus.rsp0_valid, bus.rsp0_r, bus.rsp0_zero, bus.rsp1_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0;
    int order[$];
    do_reset();
    for (int c = 0; c < 20 && (n0 < 4 || n1 < 4); c++) begin
      bus.req0_valid = (n0 < 4);
      bus.req0_a = (n0 == 0) ? 32'd9 : 32'(n0 * 3);
      bus.req0_b = (n0 == 0) ? 32'd9 : 32'd1;
      bus.req0_op = (n0 == 0) ? 4'b0100 : 4'b0011;
      bus.req1_valid = (n1 < 4);
      bus.req1_a = 32'(n1 + 100); bus.req1_b = 32'd2; bus.req1_op = 4'b0001;
      tick();
      if (last_acc0) begin order.push_back(0); n0++; end
      if (last_acc1) begin order.push_back(1); n1++; end
      if (order.size() == 1 && (last_acc0 || last_acc1)) begin
        tests_run++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_r !== 32'd0 || bus.rsp0_zero !== 1'b1) begin
          fails++;
          $display("FAIL rr_first got v0=%b r=%h z=%b exp v0=1 r=0 z=1", bus.rsp0_valid,
                   bus.rsp0_r, bus.rsp0_zero);
        end
      end
    end
    idle_inputs();
    tests_run++;
    if (order.size() != 8) begin
      fails++; $display("FAIL rr_count got %0d exp 8", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      tests_run++;
      if (order[k] != k % 2) begin
        fails++; $display("FAIL rr_order idx %0d got %0d exp %0d", k, order[k], k % 2);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_op = 4'b0011;
    tick();
    bus.req0_a = 32'd4; bus.req0_b = 32'd4; bus.req0_op = 4'b0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hf0; bus.req1_b = 32'h0f; bus.req1_op = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.rsp0_valid !== 1'b1 ||
          bus.rsp0_r !== 32'd3) begin
        fails++;
        $display("FAIL bp_hold cyc %0d got rdy=%b%b v0=%b r=%h exp rdy=00 v0=1 r=00000003", k,
                 bus.req1_ready, bus.req0_ready, bus.rsp0_valid, bus.rsp0_r);
      end
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      fails++; $display("FAIL bp_release got rdy=%b%b exp 10", bus.req1_ready, bus.req0_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    tests_run++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_r !== 32'hff) begin
      fails++;
      $display("FAIL bp_rsp1 got v1=%b v0=%b r=%h exp v1=1 v0=0 r=000000ff", bus.rsp1_valid,
               bus.rsp0_valid, bus.rsp1_r);
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    logic [31:0] av[3] = '{32'h8000_0000, 32'hffff_ffff, 32'hffff_ffff};
    logic [31:0] bv[3] = '{32'd4, 32'd2, 32'd1};
    logic [3:0]  ov[3] = '{4'b1010, 4'b0111, 4'b1100};
    logic [31:0] ev[3] = '{32'hf800_0000, 32'h0000_0001, 32'h0000_0001};
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      bus.req1_valid = 1'b1; bus.req1_a = av[k]; bus.req1_b = bv[k]; bus.req1_op = ov[k];
      tick();
      bus.req1_valid = 1'b0;
      tests_run++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_r !== ev[k]) begin
        fails++;
        $display("FAIL arith_%0d got v=%b r=%h exp v=1 r=%h", k, bus.rsp1_valid, bus.rsp1_r,
                 ev[k]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_op = 4'b0011;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    tests_run++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_r !== 32'd7) begin
      fails++; $display("FAIL mid_pending got v1=%b r=%h exp v1=1 r=7", bus.rsp1_valid, bus.rsp1_r);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp1_r !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset got v=%b%b r=%h exp v=00 r=0", bus.rsp1_valid, bus.rsp0_valid,
               bus.rsp1_r);
    end
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    tests_run++;
    if (bus.rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL mid_stale got v1=%b exp 0", bus.rsp1_valid);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'd6; bus.req0_b = 32'd3; bus.req0_op = 4'b0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd6; bus.req1_b = 32'd3; bus.req1_op = 4'b0001;
    tick();
    bus.req0_valid = 1'b0;
    tests_run++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_r !== 32'd2) begin
      fails++; $display("FAIL mid_prio got v0=%b r=%h exp v0=1 r=2", bus.rsp0_valid, bus.rsp0_r);
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.req1_valid = 1'b1; bus.req1_a = 32'(i); bus.req1_b = 32'(i); bus.req1_op = 4'b0011;
      tick();
      tests_run++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_r !== 32'(2 * i)) begin
        fails++;
        $display("FAIL stream_%0d got v=%b r=%h exp v=1 r=%h", i, bus.rsp1_valid, bus.rsp1_r,
                 32'(2 * i));
      end
    end
    bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic p0 = 1'b0, p1 = 1'b0;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1;
        bus.req0_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        bus.req0_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        bus.req0_op = 4'($urandom_range(0, 15));
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        bus.req1_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        bus.req1_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        bus.req1_op = 4'($urandom_range(0, 15));
      end
      bus.req0_valid = p0;
      bus.req1_valid = p1;
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      tick();
      if (rst) begin
        p0 = 1'b0; p1 = 1'b0;
      end else begin
        if (last_acc0) p0 = 1'b0;
        if (last_acc1) p1 = 1'b0;
      end
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_arith();
    test_reset_mid();
    test_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout run did not complete");
    $fatal(1, "timeout");
  end

endmodule
